// File: rtl/ilkn_msg_sched.sv
// Round-robin message scheduler feeding an Interlaken TX user interface.
// A granted request becomes a burst of 64-bit words tagged with timestamp, channel and word index.
module ilkn_msg_sched #(
  parameter int NUM_REQ = 9,
  parameter int LEN_W   = 8,
  parameter int TS_W    = 32
) (
  input  logic                     init_clk,
  input  logic                     clk_reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  output logic [NUM_REQ-1:0]       req_ack,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     tx_sop,
  output logic                     tx_eop,
  output logic [3:0]               tx_chan,
  output logic [63:0]              tx_data,
  output logic                     busy
);

  localparam int CH_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, SEND} state_t;

  state_t            state, state_d;
  logic [TS_W-1:0]   ts, ts_q, ts_d;
  logic [CH_W-1:0]   last_grant, last_d;
  logic [CH_W-1:0]   win_q, win_d;
  logic [CH_W-1:0]   winner;
  logic              found;
  int                cand;
  logic [LEN_W-1:0]  len_q, len_d, win_len;
  logic [LEN_W-1:0]  idx, idx_d, idx_nxt;
  logic [NUM_REQ-1:0] ack_d;
  logic              valid_d, sop_d, eop_d;
  logic [3:0]        chan_d;

  // Round-robin search: first requester at or after last_grant+1, wrapping at NUM_REQ.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch can be inferred.
    winner = '0;
    found  = 1'b0;
    cand   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(last_grant) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = CH_W'(cand);
      end
    end
  end

  assign win_len = req_len[winner*LEN_W +: LEN_W];
  assign idx_nxt = idx + LEN_W'(1);

  always_comb begin
    state_d = state;
    ack_d   = '0;
    valid_d = tx_valid;
    sop_d   = tx_sop;
    eop_d   = tx_eop;
    chan_d  = tx_chan;
    idx_d   = idx;
    len_d   = len_q;
    ts_d    = ts_q;
    last_d  = last_grant;
    win_d   = win_q;
    case (state)
      IDLE: begin
        if (found) begin
          state_d        = GRANT;
          ack_d[winner]  = 1'b1;
          last_d         = winner;
          win_d          = winner;
          len_d          = (win_len == '0) ? LEN_W'(1) : win_len;
        end
      end
      GRANT: begin
        state_d = SEND;
        ts_d    = ts;
        valid_d = 1'b1;
        sop_d   = 1'b1;
        eop_d   = (len_q == LEN_W'(1));
        chan_d  = 4'(win_q);
        idx_d   = '0;
      end
      SEND: begin
        // Outputs only move on an accepted word, so a stalled word stays put.
        if (tx_ready) begin
          if (tx_eop) begin
            state_d = IDLE;
            valid_d = 1'b0;
            sop_d   = 1'b0;
            eop_d   = 1'b0;
            chan_d  = '0;
          end else begin
            idx_d = idx_nxt;
            sop_d = 1'b0;
            eop_d = (idx_nxt == len_q - LEN_W'(1));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge init_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (clk_reset) begin
      state      <= IDLE;
      ts         <= '0;
      ts_q       <= '0;
      last_grant <= CH_W'(NUM_REQ - 1);
      win_q      <= '0;
      len_q      <= '0;
      idx        <= '0;
      req_ack    <= '0;
      tx_valid   <= 1'b0;
      tx_sop     <= 1'b0;
      tx_eop     <= 1'b0;
      tx_chan    <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      ts         <= ts + TS_W'(1);
      ts_q       <= ts_d;
      last_grant <= last_d;
      win_q      <= win_d;
      len_q      <= len_d;
      idx        <= idx_d;
      req_ack    <= ack_d;
      tx_valid   <= valid_d;
      tx_sop     <= sop_d;
      tx_eop     <= eop_d;
      tx_chan    <= chan_d;
      busy       <= (state_d != IDLE);
    end
  end

  assign tx_data = tx_valid ? {32'(ts_q), 4'h0, tx_chan, 16'h0000, 8'(idx)} : 64'h0;

endmodule

// File: tb/tb_ilkn_msg_sched.sv
// Scoreboard bench for ilkn_msg_sched: per-cycle stimulus tables, a transaction-level model
// of grants and word timing, and a negedge monitor comparing every cycle and every accepted word.
module tb_ilkn_msg_sched;

  localparam int NUM_REQ = 9;
  localparam int LEN_W   = 8;
  localparam int TS_W    = 8;   // narrow counter so the timestamp wrap is reachable
  localparam int MAXC    = 2048;

  logic        init_clk = 1'b0;
  logic        clk_reset = 1'b1;
  logic [8:0]  req_valid = '0;
  logic [71:0] req_len = '0;
  logic        tx_ready = 1'b0;
  logic [8:0]  req_ack;
  logic        tx_valid, tx_sop, tx_eop, busy;
  logic [3:0]  tx_chan;
  logic [63:0] tx_data;

  ilkn_msg_sched #(.NUM_REQ(NUM_REQ), .LEN_W(LEN_W), .TS_W(TS_W)) dut (
    .init_clk (init_clk),
    .clk_reset(clk_reset),
    .req_valid(req_valid),
    .req_len  (req_len),
    .req_ack  (req_ack),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_sop   (tx_sop),
    .tx_eop   (tx_eop),
    .tx_chan  (tx_chan),
    .tx_data  (tx_data),
    .busy     (busy)
  );

  always #5 init_clk = ~init_clk;

  typedef struct packed {
    logic        busy;
    logic        valid;
    logic        sop;
    logic        eop;
    logic [3:0]  chan;
    logic [63:0] data;
    logic [8:0]  ack;
  } obs_t;

  typedef struct packed {
    int          cyc;
    logic        sop;
    logic        eop;
    logic [3:0]  chan;
    logic [63:0] data;
  } word_t;

  logic [8:0]  in_req[MAXC];
  logic [71:0] in_len[MAXC];
  bit          in_ready[MAXC];
  obs_t        exp_cyc[MAXC];
  word_t       sb[$];

  int   n_cmp = 0;
  int   n_err = 0;
  int   cur = 0;
  int   lim = 0;
  bit   running = 1'b0;
  obs_t act_obs;
  word_t exp_word;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cur, act, exp);
    end
  endtask

  function automatic int rr(input int last, input logic [8:0] req);
    for (int k = 1; k <= NUM_REQ; k++) begin
      int c;
      c = (last + k) % NUM_REQ;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  // Transaction-level prediction: an idle cycle with any request yields an ack the next cycle,
  // then one presented word per cycle until len words are accepted; the cycle after eop is idle.
  task automatic build(input int n, input int l);
    int j, last, w, len, g, k, idx;
    obs_t o;
    for (int i = 0; i < n; i++) exp_cyc[i] = '0;
    sb.delete();
    j = 0;
    last = NUM_REQ - 1;
    while (j < n) begin
      if (in_req[j] == '0) begin
        j++;
      end else begin
        w = rr(last, in_req[j]);
        last = w;
        len = int'(in_len[j][w*8 +: 8]);
        if (len == 0) len = 1;
        g = j + 1;
        if (g < n) begin
          exp_cyc[g].busy = 1'b1;
          exp_cyc[g].ack  = 9'(1) << w;
        end
        k = g + 1;
        idx = 0;
        while (idx < len && k < n) begin
          o = '0;
          o.busy  = 1'b1;
          o.valid = 1'b1;
          o.sop   = (idx == 0);
          o.eop   = (idx == len - 1);
          o.chan  = 4'(w);
          o.data  = {32'(g % (1 << TS_W)), 8'(w), 16'h0000, 8'(idx)};
          exp_cyc[k] = o;
          if (in_ready[k]) begin
            if (k <= l) sb.push_back('{k, o.sop, o.eop, o.chan, o.data});
            idx++;
          end
          k++;
        end
        j = k;
      end
    end
  endtask

  task automatic clear(input int n);
    for (int i = 0; i < n; i++) begin
      in_req[i]   = '0;
      in_len[i]   = '0;
      in_ready[i] = 1'b1;
    end
  endtask

  task automatic set_len(input int n, input int src, input int len);
    for (int i = 0; i < n; i++) in_len[i][src*8 +: 8] = 8'(len);
  endtask

  task automatic drive(input int j);
    req_valid = in_req[j];
    req_len   = in_len[j];
    tx_ready  = in_ready[j];
  endtask

  // Runs n table cycles from reset; a limit below n-1 raises reset during that cycle (abort).
  task automatic run(input int n, input int l);
    build(n, l);
    lim = l;
    clk_reset = 1'b1;
    req_valid = '0;
    tx_ready  = 1'b0;
    @(posedge init_clk);
    @(negedge init_clk);
    check("reset_state", {busy, tx_valid, tx_sop, tx_eop, tx_chan, tx_data, req_ack}, '0);
    @(posedge init_clk);
    #1;
    clk_reset = 1'b0;
    cur = 0;
    drive(0);
    running = 1'b1;
    for (int j = 1; j <= l; j++) begin
      @(posedge init_clk);
      #1;
      cur = j;
      drive(j);
    end
    if (l < n - 1) clk_reset = 1'b1;
    @(negedge init_clk);
    #1;
    running = 1'b0;
    check("scoreboard_drain", 128'(sb.size()), '0);
  endtask

  always @(negedge init_clk) begin
    if (running) begin
      act_obs = {busy, tx_valid, tx_sop, tx_eop, tx_chan, tx_data, req_ack};
      check("cycle_outputs", act_obs, exp_cyc[cur]);
      if (tx_valid && tx_ready) begin
        if (sb.size() == 0) begin
          check("word_unexpected", {tx_valid, tx_ready}, '0);
        end else begin
          exp_word = sb.pop_front();
          check("accepted_word", {cur, tx_sop, tx_eop, tx_chan, tx_data}, exp_word);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached at cycle=%0d", cur);
    $fatal(1, "watchdog");
  end

  initial begin
    int j, span;
    logic [8:0]  r;
    logic [71:0] lv;

    // Single 3-word message from source 2.
    clear(20);
    in_req[2] = 9'h004;
    set_len(20, 2, 3);
    run(20, 19);

    // All sources held with length 1: grants 0..8 then 0 again, one per 3 cycles.
    clear(40);
    for (int i = 0; i < 30; i++) in_req[i] = 9'h1FF;
    for (int s = 0; s < NUM_REQ; s++) set_len(40, s, 1);
    run(40, 39);

    // Length 0 on source 5 is a single sop+eop word.
    clear(12);
    in_req[1] = 9'h020;
    run(12, 11);

    // Backpressure on a 4-word message.
    clear(20);
    in_req[0] = 9'h001;
    set_len(20, 0, 4);
    in_ready[2] = 1; in_ready[3] = 0; in_ready[4] = 0; in_ready[5] = 1;
    in_ready[6] = 1; in_ready[7] = 0; in_ready[8] = 1;
    run(20, 19);

    // Reset during the second word of a 5-word message from source 1.
    clear(20);
    in_req[0] = 9'h002;
    set_len(20, 1, 5);
    run(20, 3);

    // After that reset the search starts at source 0 again, so source 1 beats source 2.
    clear(12);
    in_req[0] = 9'h006;
    set_len(12, 1, 2);
    run(12, 11);

    // Grant on the counter's last value, then another after the wrap.
    clear(300);
    in_req[254] = 9'h010;
    for (int i = 256; i < 259; i++) in_req[i] = 9'h100;
    set_len(300, 8, 2);
    run(300, 299);

    // Randomized requests, lengths and backpressure, then a quiet drain tail.
    clear(1800);
    j = 0;
    while (j < 1500) begin
      span = $urandom_range(1, 20);
      r = ($urandom_range(0, 3) == 0) ? 9'h000 : 9'($urandom);
      for (int s = 0; s < NUM_REQ; s++)
        lv[s*8 +: 8] = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
      for (int i = j; i < j + span && i < 1500; i++) begin
        in_req[i]   = r;
        in_len[i]   = lv;
        in_ready[i] = ($urandom_range(0, 9) < 7);
      end
      j = j + span;
    end
    run(1800, 1799);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
